pes_sysarray_ctrl: RTL and testbench
====================================

Name: pes_sysarray_ctrl

Overview:
Sequencing controller for the pes_sysarray systolic matrix multiplier. On a start pulse it runs one or more 8x8 tiles back to back. For each tile it:
- issues weight and data SRAM read addresses,
- drives alu_start and cycle_num into the array,
- steps matrix_index through the result rows while writing each row to the output SRAM.

It sits between the top-level command interface and pes_sysarray plus its SRAMs.

Parameters:
ARRAY_SIZE, 8, systolic array dimension; rows fed and rows written back per tile
ADDR_WIDTH, 10, SRAM address width (read and write)
RUN_LEN, 3*ARRAY_SIZE-2, number of array compute cycles per tile (fill, skew and drain)

Ports:
clk  input  1  clock, all state updates on rising edge
srstn  input  1  asynchronous active-low reset
start  input  1  one-cycle request pulse; sampled only in IDLE
num_tiles  input  8  tiles to process; latched when start is accepted
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
sram_raddr_w  output  ADDR_WIDTH  read address shared by weight banks w0/w1
sram_raddr_d  output  ADDR_WIDTH  read address shared by data banks d0/d1
alu_start  output  1  array enable
cycle_num  output  9  array cycle index
matrix_index  output  6  result-row select into mul_outcome
sram_wen  output  1  output SRAM write enable, active high
sram_waddr  output  ADDR_WIDTH  output SRAM write address

Behaviour:
- Reset (srstn=0, asynchronous): state goes to IDLE. All outputs and internal counters (tile_idx, cnt) are 0. Reset mid-tile abandons the tile with no done pulse.
- SRAM read latency is 1 cycle. Addresses therefore lead alu_start/cycle_num by one cycle.
- Tile read base rbase = tile_idx*ARRAY_SIZE, computed modulo 2^ADDR_WIDTH (wraps silently).
- FSM states: IDLE, PREFETCH, RUN, WRITE, FIN.
- IDLE:
  - start=1 and num_tiles!=0: latch num_tiles, tile_idx<=0, go to PREFETCH.
  - start=1 and num_tiles==0: go to FIN without touching the array.
  - start is ignored in every other state (no queuing).
- PREFETCH (1 cycle): sram_raddr_w = sram_raddr_d = rbase; alu_start=0. Next state RUN with cycle_num<=0.
- RUN (RUN_LEN cycles):
  - alu_start=1; cycle_num counts 0..RUN_LEN-1.
  - Read addresses are rbase+cycle_num+1 while cycle_num+1 < ARRAY_SIZE, then held at rbase+ARRAY_SIZE-1.
  - After cycle_num=RUN_LEN-1: go to WRITE, alu_start<=0, cycle_num<=0.
- WRITE (ARRAY_SIZE cycles):
  - sram_wen=1; matrix_index counts 0..ARRAY_SIZE-1.
  - sram_waddr = tile_idx*ARRAY_SIZE + matrix_index.
  - After the last row: tile_idx+1 < num_tiles goes to PREFETCH with tile_idx incremented; otherwise go to FIN.
- FIN (1 cycle): done=1, busy=0, then IDLE.
- busy: 1 in PREFETCH, RUN and WRITE; 0 in IDLE and FIN.
- Outside their owning state, cycle_num, matrix_index and sram_wen are 0. Read addresses hold their last value.
- All outputs are registered (driven from flops, no combinational paths from start).
- Cycles per tile: 1 + RUN_LEN + ARRAY_SIZE, which is 31 for the defaults.

Test Plan:
- Reset: assert srstn=0 mid-RUN of tile 0 -> all outputs 0 in the same cycle (asynchronous); after release, state is IDLE and no done pulse appears.
- Single tile, num_tiles=1, start at edge T:
  - busy is high on edges T+1..T+31.
  - alu_start is high on exactly 22 consecutive cycles, with cycle_num 0..21.
  - sram_raddr_w/d sequence is 0,1,...,7, held at 7.
  - sram_wen is high on 8 cycles with sram_waddr 0..7 and matrix_index 0..7.
  - done is pulsed once at T+32.
- Three tiles, num_tiles=3:
  - read bases are 0, 8, 16; write addresses are 0..23 in order;
  - no gap cycles beyond PREFETCH between tiles;
  - done occurs exactly 93 cycles after start acceptance.
- num_tiles=0 with start -> done one cycle after acceptance; busy, alu_start and sram_wen never assert.
- start pulsed while busy (during RUN and during WRITE) -> ignored; tile count and timing are identical to the single-tile case.
- Back-to-back: start asserted in the cycle after done -> accepted; the second run matches the first cycle-for-cycle.

Source files
------------

// File: rtl/pes_sysarray_ctrl.sv
// Sequencing controller for the pes_sysarray systolic multiplier: runs a batch of
// 8x8 tiles through prefetch, compute and row write-back, with all outputs registered.
module pes_sysarray_ctrl #(
    parameter int ARRAY_SIZE = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RUN_LEN    = 3*ARRAY_SIZE-2
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  start,
    input  logic [7:0]            num_tiles,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sram_raddr_w,
    output logic [ADDR_WIDTH-1:0] sram_raddr_d,
    output logic                  alu_start,
    output logic [8:0]            cycle_num,
    output logic [5:0]            matrix_index,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_waddr
);

    typedef enum logic [2:0] {IDLE, PREFETCH, RUN, WRITE, FIN} state_t;

    localparam logic [8:0]            LAST_CYC  = 9'(RUN_LEN-1);
    localparam logic [8:0]            AS_CYC    = 9'(ARRAY_SIZE);
    localparam logic [5:0]            LAST_ROW  = 6'(ARRAY_SIZE-1);
    localparam logic [ADDR_WIDTH-1:0] AS_ADDR   = ADDR_WIDTH'(ARRAY_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_OFS  = ADDR_WIDTH'(ARRAY_SIZE-1);

    state_t                  state_q, state_n;
    logic [7:0]              tile_q, tile_n;
    logic [7:0]              ntiles_q, ntiles_n;
    logic [ADDR_WIDTH-1:0]   raddr_q, raddr_n;
    logic [ADDR_WIDTH-1:0]   rbase, rbase_next;
    logic                    busy_n, done_n, alu_n, wen_n;
    logic [8:0]              cyc_n;
    logic [5:0]              row_n;
    logic [ADDR_WIDTH-1:0]   waddr_n;

    assign rbase        = ADDR_WIDTH'(tile_q) * AS_ADDR;
    assign rbase_next   = ADDR_WIDTH'(tile_q + 8'd1) * AS_ADDR;
    assign sram_raddr_w = raddr_q;
    assign sram_raddr_d = raddr_q;

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_n  = state_q;
        tile_n   = tile_q;
        ntiles_n = ntiles_q;
        raddr_n  = raddr_q;
        waddr_n  = sram_waddr;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        alu_n    = 1'b0;
        wen_n    = 1'b0;
        cyc_n    = '0;
        row_n    = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_tiles != 8'd0) begin
                        ntiles_n = num_tiles;
                        tile_n   = '0;
                        raddr_n  = '0;
                        busy_n   = 1'b1;
                        state_n  = PREFETCH;
                    end else begin
                        done_n   = 1'b1;
                        state_n  = FIN;
                    end
                end
            end
            PREFETCH: begin
                busy_n  = 1'b1;
                alu_n   = 1'b1;
                raddr_n = rbase + ADDR_WIDTH'(1);
                state_n = RUN;
            end
            RUN: begin
                busy_n = 1'b1;
                if (cycle_num == LAST_CYC) begin
                    wen_n   = 1'b1;
                    waddr_n = rbase;
                    state_n = WRITE;
                end else begin
                    alu_n = 1'b1;
                    cyc_n = cycle_num + 9'd1;
                    // address leads data by one cycle: fetch row (next cycle_num)+1
                    if (cycle_num + 9'd2 < AS_CYC) raddr_n = rbase + ADDR_WIDTH'(cycle_num + 9'd2);
                    else                           raddr_n = rbase + LAST_OFS;
                end
            end
            WRITE: begin
                if (matrix_index == LAST_ROW) begin
                    if ({1'b0, tile_q} + 9'd1 < {1'b0, ntiles_q}) begin
                        busy_n  = 1'b1;
                        tile_n  = tile_q + 8'd1;
                        raddr_n = rbase_next;
                        state_n = PREFETCH;
                    end else begin
                        done_n  = 1'b1;
                        state_n = FIN;
                    end
                end else begin
                    busy_n  = 1'b1;
                    wen_n   = 1'b1;
                    row_n   = matrix_index + 6'd1;
                    waddr_n = rbase + ADDR_WIDTH'(matrix_index + 6'd1);
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q      <= IDLE;
            tile_q       <= '0;
            ntiles_q     <= '0;
            raddr_q      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            alu_start    <= 1'b0;
            cycle_num    <= '0;
            matrix_index <= '0;
            sram_wen     <= 1'b0;
            sram_waddr   <= '0;
        end else begin
            state_q      <= state_n;
            tile_q       <= tile_n;
            ntiles_q     <= ntiles_n;
            raddr_q      <= raddr_n;
            busy         <= busy_n;
            done         <= done_n;
            alu_start    <= alu_n;
            cycle_num    <= cyc_n;
            matrix_index <= row_n;
            sram_wen     <= wen_n;
            sram_waddr   <= waddr_n;
        end
    end

endmodule

// File: tb/tb_pes_sysarray_ctrl.sv
// Self-checking bench for pes_sysarray_ctrl: every output is compared each cycle
// against a per-cycle expectation derived from the tile schedule arithmetic.
module tb_pes_sysarray_ctrl;

    localparam int AS  = 8;
    localparam int RL  = 3*AS-2;
    localparam int PER = 1 + RL + AS;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       alu;
        logic [8:0] cyc;
        logic [5:0] mi;
        logic       wen;
        logic [9:0] waddr;
        logic [9:0] rw;
        logic [9:0] rd;
    } outs_t;

    logic       clk = 1'b0;
    logic       srstn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_tiles = '0;
    logic       busy, done, alu_start, sram_wen;
    logic [9:0] sram_raddr_w, sram_raddr_d, sram_waddr;
    logic [8:0] cycle_num;
    logic [5:0] matrix_index;

    int checks = 0;
    int errors = 0;
    int last_ra = 0;

    always #5 clk = ~clk;

    pes_sysarray_ctrl #(.ARRAY_SIZE(AS), .ADDR_WIDTH(10)) dut (
        .clk(clk), .srstn(srstn), .start(start), .num_tiles(num_tiles),
        .busy(busy), .done(done), .sram_raddr_w(sram_raddr_w), .sram_raddr_d(sram_raddr_d),
        .alu_start(alu_start), .cycle_num(cycle_num), .matrix_index(matrix_index),
        .sram_wen(sram_wen), .sram_waddr(sram_waddr)
    );

    // k counts cycles after the accepting edge; each tile is PER cycles: prefetch, run, write.
    function automatic outs_t model(int n, int k, int prev_ra);
        outs_t o;
        int t, p, base, ra;
        o  = '0;
        ra = prev_ra;
        if (n > 0 && k < PER*n) begin
            t = k / PER;
            p = k % PER;
            base = (t*AS) % 1024;
            o.busy = 1'b1;
            if (p == 0) begin
                ra = base;
            end else if (p <= RL) begin
                o.alu = 1'b1;
                o.cyc = 9'(p-1);
                ra = base + ((p < AS-1) ? p : AS-1);
            end else begin
                o.wen = 1'b1;
                o.mi = 6'(p-RL-1);
                o.waddr = 10'((base + p - RL - 1) % 1024);
                ra = base + AS - 1;
            end
        end else begin
            o.done = (k == PER*n);
            if (n > 0) ra = (n-1)*AS + AS - 1;
        end
        o.rw = 10'(ra % 1024);
        o.rd = o.rw;
        return o;
    endfunction

    function automatic outs_t observe(logic keep_waddr);
        outs_t o;
        o.busy = busy; o.done = done; o.alu = alu_start; o.cyc = cycle_num;
        o.mi = matrix_index; o.wen = sram_wen;
        o.waddr = keep_waddr ? sram_waddr : 10'd0;
        o.rw = sram_raddr_w; o.rd = sram_raddr_d;
        return o;
    endfunction

    function automatic int final_ra(int n, int prev_ra);
        return (n > 0) ? ((n-1)*AS + AS - 1) % 1024 : prev_ra;
    endfunction

    task automatic start_run(input int n);
        @(negedge clk);
        start = 1'b1;
        num_tiles = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        outs_t e, o;
        o = observe(1'b1);
        checks++;
        if (o !== outs_t'(0)) begin errors++; $display("FAIL reset_state got %h exp 0", o); end
        @(negedge clk) srstn = 1'b1;
        start_run(1);
        for (int k = 0; k <= 10; k++) begin
            e = model(1, k, last_ra); o = observe(e.wen);
            checks++;
            if (o !== e) begin errors++; $display("FAIL pre_reset k=%0d got %h exp %h", k, o, e); end
            @(posedge clk); #1;
        end
        #2 srstn = 1'b0;
        #1;
        o = observe(1'b1);
        checks++;
        if (o !== outs_t'(0)) begin errors++; $display("FAIL async_reset got %h exp 0", o); end
        @(negedge clk) srstn = 1'b1;
        last_ra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            o = observe(1'b1);
            checks++;
            if (o !== outs_t'(0)) begin errors++; $display("FAIL post_reset_idle k=%0d got %h exp 0", k, o); end
        end
    endtask

    task automatic test_tiles(input int n, input string name);
        outs_t e, o;
        start_run(n);
        for (int k = 0; k < PER*n + 2; k++) begin
            e = model(n, k, last_ra); o = observe(e.wen);
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s n=%0d k=%0d got %h exp %h", name, n, k, o, e); end
            @(posedge clk); #1;
        end
        last_ra = final_ra(n, last_ra);
    endtask

    task automatic test_ignore_start();
        outs_t e, o;
        start_run(1);
        for (int k = 0; k < PER + 2; k++) begin
            e = model(1, k, last_ra); o = observe(e.wen);
            checks++;
            if (o !== e) begin errors++; $display("FAIL ignore_start k=%0d got %h exp %h", k, o, e); end
            if (k == 5 || k == 25) begin
                start = 1'b1;
                num_tiles = 8'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        last_ra = final_ra(1, last_ra);
    endtask

    task automatic test_back_to_back();
        outs_t e, o;
        int n1, n2;
        n1 = $urandom_range(1, 3);
        n2 = $urandom_range(1, 3);
        start_run(n1);
        for (int k = 0; k < PER*n1 + 2; k++) begin
            e = model(n1, k, last_ra); o = observe(e.wen);
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_first n=%0d k=%0d got %h exp %h", n1, k, o, e); end
            // start held through the done cycle (ignored) and the idle cycle after it (accepted)
            if (k == PER*n1) begin
                start = 1'b1;
                num_tiles = 8'(n2);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        last_ra = final_ra(n1, last_ra);
        for (int k = 0; k < PER*n2 + 2; k++) begin
            e = model(n2, k, last_ra); o = observe(e.wen);
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_second n=%0d k=%0d got %h exp %h", n2, k, o, e); end
            @(posedge clk); #1;
        end
        last_ra = final_ra(n2, last_ra);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_tiles(1, "single");
        test_tiles(3, "three_tiles");
        test_tiles($urandom_range(2, 6), "multi_rand");
        test_tiles(0, "zero_tiles");
        test_ignore_start();
        test_back_to_back();
        test_tiles(130, "addr_wrap");
        test_tiles(0, "zero_after_wrap");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
